// File: rtl/seq_divider_8by4.sv
// -----------------------------------------------------------------------------
// seq_divider_8by4
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock using shift-left / trial-subtract. Start/busy/done handshake;
// quotient, remainder and div_by_zero hold until the next accepted start.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high, highest priority
//   start        request, sampled only in IDLE or DONE
//   dividend     DIVIDEND_W operand, captured on the accepted start edge
//   divisor      DIVISOR_W operand, captured on the accepted start edge
//   busy         high while iterating
//   done         one-cycle pulse when results are valid
//   quotient     DIVIDEND_W result
//   remainder    DIVISOR_W result
//   div_by_zero  captured divisor was zero; held with the results
// -----------------------------------------------------------------------------
module seq_divider_8by4 #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t                  state_r, state_nxt_s;

   // Working registers. The partial remainder only ever needs its low
   // DIVISOR_W bits carried between iterations: after a successful subtract
   // it is below the divisor, and when the subtract fails the shifted-out
   // top bit never re-enters the result.
   logic [DIVIDEND_W-1:0]   q_r, q_nxt_s;
   logic [DIVISOR_W-1:0]    d_r, d_nxt_s;
   logic [DIVISOR_W-1:0]    r_r, r_nxt_s;
   logic [CNT_W-1:0]        count_r, count_nxt_s;

   logic                    busy_r, busy_nxt_s;
   logic                    done_r, done_nxt_s;
   logic [DIVIDEND_W-1:0]   quotient_r, quotient_nxt_s;
   logic [DIVISOR_W-1:0]    remainder_r, remainder_nxt_s;
   logic                    dz_r, dz_nxt_s;

   // One restoring step
   logic [DIVISOR_W:0]      t_s;
   logic                    ge_s;
   logic [DIVISOR_W-1:0]    r_iter_s;
   logic [DIVIDEND_W-1:0]   q_iter_s;

   // Single restoring-division step on the current working registers
   always_comb begin
      t_s      = {r_r, q_r[DIVIDEND_W-1]};
      ge_s     = (t_s >= {1'b0, d_r});
      r_iter_s = t_s[DIVISOR_W-1:0];
      q_iter_s = {q_r[DIVIDEND_W-2:0], 1'b0};
      if (ge_s) begin
         // Low bits of T-D are exact modulo 2^DIVISOR_W
         r_iter_s = t_s[DIVISOR_W-1:0] - d_r;
         q_iter_s = {q_r[DIVIDEND_W-2:0], 1'b1};
      end else begin
         r_iter_s = t_s[DIVISOR_W-1:0];
         q_iter_s = {q_r[DIVIDEND_W-2:0], 1'b0};
      end
   end

   // Next-state and next-value logic for the FSM and its datapath
   always_comb begin
      state_nxt_s     = state_r;
      q_nxt_s         = q_r;
      d_nxt_s         = d_r;
      r_nxt_s         = r_r;
      count_nxt_s     = count_r;
      busy_nxt_s      = busy_r;
      done_nxt_s      = 1'b0;
      quotient_nxt_s  = quotient_r;
      remainder_nxt_s = remainder_r;
      dz_nxt_s        = dz_r;

      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_nxt_s = RUN;
               q_nxt_s     = dividend;
               d_nxt_s     = divisor;
               r_nxt_s     = {DIVISOR_W{1'b0}};
               count_nxt_s = CNT_W'(DIVIDEND_W);
               busy_nxt_s  = 1'b1;
               dz_nxt_s    = (divisor == {DIVISOR_W{1'b0}});
            end else begin
               state_nxt_s = IDLE;
               busy_nxt_s  = 1'b0;
            end
         end
         RUN: begin
            // start is ignored here; operands stay as captured
            q_nxt_s     = q_iter_s;
            r_nxt_s     = r_iter_s;
            count_nxt_s = count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
               // Final step: publish results in the same edge
               state_nxt_s     = DONE;
               busy_nxt_s      = 1'b0;
               done_nxt_s      = 1'b1;
               quotient_nxt_s  = q_iter_s;
               remainder_nxt_s = r_iter_s;
            end else begin
               state_nxt_s = RUN;
               busy_nxt_s  = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r         <= {DIVIDEND_W{1'b0}};
         d_r         <= {DIVISOR_W{1'b0}};
         r_r         <= {DIVISOR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         quotient_r  <= {DIVIDEND_W{1'b0}};
         remainder_r <= {DIVISOR_W{1'b0}};
         dz_r        <= 1'b0;
      end else begin
         q_r         <= q_nxt_s;
         d_r         <= d_nxt_s;
         r_r         <= r_nxt_s;
         count_r     <= count_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         quotient_r  <= quotient_nxt_s;
         remainder_r <= remainder_nxt_s;
         dz_r        <= dz_nxt_s;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dz_r;

endmodule

// File: tb/tb_seq_divider_8by4.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_8by4
// Self-checking bench for seq_divider_8by4. Expected results come from plain
// integer division (/ and %) with the divide-by-zero rule applied on top.
// -----------------------------------------------------------------------------
module tb_seq_divider_8by4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_divider_8by4 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic plus the divide-by-zero rule
   function automatic void model(input int a, input int b,
                                 output int eq, output int er, output int edz);
      if (b == 0) begin
         eq = 255; er = a % 16; edz = 1;
      end else begin
         eq = a / b; er = a % b; edz = 0;
      end
   endfunction

   // Launch one divide (caller is at post-edge time, DUT in IDLE/DONE).
   // Returns edges from acceptance to done, and cycles busy was seen high.
   task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                          output int lat, output int busy_cyc);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; busy_cyc = 0;
      if (busy === 1'b1) busy_cyc++;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
         if (busy === 1'b1) busy_cyc++;
      end
   endtask

   task automatic check_result(input string name, input int a, input int b);
      int eq, er, edz;
      model(a, b, eq, er, edz);
      checks++;
      if (quotient !== 8'(eq) || remainder !== 4'(er) || div_by_zero !== 1'(edz)) begin
         errors++;
         $display("FAIL %s %0d/%0d: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=%0d",
                  name, a, b, quotient, remainder, div_by_zero, eq, er, edz);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
          remainder !== 4'd0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat, bc;
      run_div(8'd143, 4'd11, lat, bc);
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL latency_143_11: got %0d expected 8", lat);
      end
      check_result("basic", 143, 11);

      run_div(8'd200, 4'd7, lat, bc);
      check_result("basic", 200, 7);
      checks++;
      if (bc !== 8) begin
         errors++; $display("FAIL busy_cycles: got %0d expected 8", bc);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL busy_at_done: got %b expected 0", busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse: got %b expected 0 one cycle later", done);
      end
      checks++;
      if (quotient !== 8'd28 || remainder !== 4'd4) begin
         errors++;
         $display("FAIL result_hold: got q=%0d r=%0d expected 28 r4", quotient, remainder);
      end
   endtask

   task automatic test_edges();
      int lat, bc;
      int as [4] = '{255, 9, 0, 90};
      int bs [4] = '{1, 15, 5, 0};
      for (int k = 0; k < 4; k++) begin
         run_div(8'(as[k]), 4'(bs[k]), lat, bc);
         check_result("edge", as[k], bs[k]);
         checks++;
         if (lat !== 8) begin
            errors++;
            $display("FAIL edge_latency %0d/%0d: got %0d expected 8", as[k], bs[k], lat);
         end
      end
   endtask

   task automatic test_ignore_mid_run();
      int lat;
      dividend = 8'd143; divisor = 4'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin
            dividend = 8'd50; divisor = 4'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL ignore_latency: got %0d expected 8", lat);
      end
      check_result("ignore_mid_run", 143, 11);
   endtask

   task automatic test_back_to_back();
      int lat, bc;
      run_div(8'd200, 4'd7, lat, bc);
      // still in the DONE cycle: request the next divide immediately
      dividend = 8'd99; divisor = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
      end
      checks++;
      if (quotient !== 8'd28 || remainder !== 4'd4) begin
         errors++;
         $display("FAIL b2b_hold: got q=%0d r=%0d expected 28 r4", quotient, remainder);
      end
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL b2b_latency: got %0d expected 8", lat);
      end
      check_result("back_to_back", 99, 5);
   endtask

   task automatic test_reset_mid_op();
      int lat, bc;
      run_div(8'd143, 4'd11, lat, bc);
      dividend = 8'd200; divisor = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
          remainder !== 4'd0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_op: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                  busy, done, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
      end
      run_div(8'd100, 4'd3, lat, bc);
      checks++;
      if (lat !== 8) begin
         errors++; $display("FAIL post_reset_latency: got %0d expected 8", lat);
      end
      check_result("post_reset", 100, 3);
   endtask

   task automatic test_random();
      int lat, bc, a, b;
      for (int n = 0; n < 500; n++) begin
         a = int'($urandom_range(255, 0));
         b = int'($urandom_range(15, 0));
         run_div(8'(a), 4'(b), lat, bc);
         check_result("random", a, b);
         checks++;
         if (lat !== 8) begin
            errors++; $display("FAIL random_latency %0d/%0d: got %0d expected 8", a, b, lat);
         end
         if (b != 0) begin
            checks++;
            if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b) begin
               errors++;
               $display("FAIL invariant %0d/%0d: q=%0d r=%0d", a, b, quotient, remainder);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_ignore_mid_run();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
